// File: rtl/fcvt_pkg.sv
// fcvt_pkg: shared types and constants for the int-to-float converter scheduler.
//   FCVT_LAT    : converter latency in clock edges (operand sampled -> result registered)
//   FCVT_IDW    : requester ID width used by the tracking and response types
//   id_t        : requester index
//   trk_t       : one in-flight tracking stage {valid, id}
//   fcvt_resp_t : one result FIFO entry {float data, requester id}
package fcvt_pkg;

    localparam int unsigned FCVT_LAT = 2;
    localparam int unsigned FCVT_IDW = 2;

    typedef logic [FCVT_IDW-1:0] id_t;

    typedef struct packed {
        logic v;
        id_t  id;
    } trk_t;

    typedef struct packed {
        logic [31:0] d;
        id_t         id;
    } fcvt_resp_t;

endpackage

// File: rtl/fcvt_rr_arb.sv
// fcvt_rr_arb: N-way round-robin priority pick.
// The search starts at ptr_i+1 and wraps, so the last winner has lowest priority.
//   valid_i : per-requester candidates
//   ptr_i   : index of the previous winner
//   gnt_c_o : one-hot grant (combinational)
//   idx_c_o : index of the granted requester (combinational)
//   any_c_o : some requester was granted (combinational)
module fcvt_rr_arb #(
    parameter int unsigned N  = 3,
    parameter int unsigned IW = 2
) (
    input  logic [N-1:0]  valid_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_c_o,
    output logic [IW-1:0] idx_c_o,
    output logic          any_c_o
);

    logic [IW-1:0] cand;

    // Walk the N candidates in rotated order; the first valid one wins.
    always_comb begin
        gnt_c_o = '0;
        idx_c_o = '0;
        any_c_o = 1'b0;
        cand    = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = IW'((32'(ptr_i) + k) % N);
            if (!any_c_o && valid_i[cand]) begin
                any_c_o       = 1'b1;
                idx_c_o       = cand;
                gnt_c_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fcvt_sched.sv
// fcvt_sched: shares one fixed-latency int-to-float converter among N requesters.
// Adds round-robin issue, in-flight {valid,id} tracking matched to the converter
// latency, and a result FIFO whose credit check guarantees no result is dropped.
// Ports:
//   clk, rstn        : clock, asynchronous active-low reset
//   req_valid/data   : per-requester operand valid and signed 32-bit operand
//   req_ready        : one-hot grant (combinational, may depend on req_valid)
//   cvt_x / cvt_y    : operand to / result from the converter
//   resp_valid/data/id, resp_ready : registered FIFO head and consumer handshake
// Optional macro FCVT_SCHED_PERF_EN adds perf_issued / perf_stall counters.
module fcvt_sched
    import fcvt_pkg::*;
#(
    parameter int unsigned N     = 3,
    parameter int unsigned IDW   = FCVT_IDW,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned LAT   = FCVT_LAT
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [N-1:0]    req_valid,
    input  logic [N*32-1:0] req_data,
    output logic [N-1:0]    req_ready,
    output logic [31:0]     cvt_x,
    input  logic [31:0]     cvt_y,
    output logic            resp_valid,
    output logic [31:0]     resp_data,
    output logic [IDW-1:0]  resp_id,
    input  logic            resp_ready
`ifdef FCVT_SCHED_PERF_EN
    ,
    output logic [31:0]     perf_issued,
    output logic [31:0]     perf_stall
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    // Elaboration-time parameter sanity.
    if (IDW != FCVT_IDW) begin : g_bad_idw
        $error("fcvt_sched: IDW must equal fcvt_pkg::FCVT_IDW");
    end
    if ((1 << IDW) < N || N < 2) begin : g_bad_n
        $error("fcvt_sched: N out of range for IDW");
    end
    if (DEPTH < 2 || DEPTH < LAT || (DEPTH & (DEPTH - 1)) != 0 || LAT < 1) begin : g_bad_depth
        $error("fcvt_sched: DEPTH must be a power of two >= max(2, LAT)");
    end

    logic [IDW-1:0] ptr_q, ptr_d;
    logic [N-1:0]   arb_valid;
    logic [N-1:0]   gnt;
    logic [IDW-1:0] gnt_idx;
    logic           gnt_any;
    logic           issue_ok;
    logic           xfer;
    logic [31:0]    infl_cnt;

    trk_t           trk_q [LAT];
    trk_t           trk_d [LAT];

    fcvt_resp_t     mem_q [DEPTH];
    logic [AW-1:0]  wr_q, wr_d;
    logic [AW-1:0]  rd_q, rd_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    fcvt_resp_t     head_q, head_d;
    logic           hv_q, hv_d;
    logic           push;
    logic           pop;

    // Credit: FIFO occupancy plus in-flight ops must leave room; same-cycle pops are not credited.
    always_comb begin
        infl_cnt = '0;
        for (int unsigned s = 0; s < LAT; s++) begin
            infl_cnt = infl_cnt + 32'(trk_q[s].v);
        end
        issue_ok  = (32'(cnt_q) + infl_cnt) < DEPTH;
        arb_valid = req_valid & {N{issue_ok}};
    end

    fcvt_rr_arb #(
        .N  (N),
        .IW (IDW)
    ) u_arb (
        .valid_i (arb_valid),
        .ptr_i   (ptr_q),
        .gnt_c_o (gnt),
        .idx_c_o (gnt_idx),
        .any_c_o (gnt_any)
    );

    assign req_ready = gnt;
    assign xfer      = gnt_any;

    // Operand mux: granted requester's data, zero when idle.
    always_comb begin
        cvt_x = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (gnt[i]) begin
                cvt_x = req_data[i*32 +: 32];
            end
        end
    end

    // Pointer and tracker next state.
    always_comb begin
        ptr_d    = xfer ? gnt_idx : ptr_q;
        trk_d[0] = '{v: xfer, id: FCVT_IDW'(gnt_idx)};
        for (int unsigned s = 1; s < LAT; s++) begin
            trk_d[s] = trk_q[s-1];
        end
    end

    // FIFO next state; the head register is reloaded from the post-update read pointer,
    // bypassing the incoming result when it lands directly at the head.
    always_comb begin
        push   = trk_q[LAT-1].v;
        pop    = hv_q && resp_ready;
        wr_d   = wr_q + AW'(push);
        rd_d   = rd_q + AW'(pop);
        cnt_d  = cnt_q + CW'(push) - CW'(pop);
        hv_d   = (cnt_d != '0);
        head_d = head_q;
        if (cnt_d != '0) begin
            if (push && (wr_q == rd_d)) begin
                head_d = '{d: cvt_y, id: trk_q[LAT-1].id};
            end else begin
                head_d = mem_q[rd_d];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr_q  <= IDW'(N - 1);
            for (int unsigned s = 0; s < LAT; s++) begin
                trk_q[s] <= '0;
            end
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            hv_q   <= 1'b0;
            head_q <= '0;
        end else begin
            ptr_q  <= ptr_d;
            for (int unsigned s = 0; s < LAT; s++) begin
                trk_q[s] <= trk_d[s];
            end
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            cnt_q  <= cnt_d;
            hv_q   <= hv_d;
            head_q <= head_d;
        end
    end

    // Result storage; contents are only meaningful under the count, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_q] <= '{d: cvt_y, id: trk_q[LAT-1].id};
        end
    end

    assign resp_valid = hv_q;
    assign resp_data  = head_q.d;
    assign resp_id    = IDW'(head_q.id);

    a_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
        !(push && (cnt_q == CW'(DEPTH)) && !pop));

    a_onehot_grant: assert property (@(posedge clk) disable iff (!rstn)
        $onehot0(req_ready));

`ifdef FCVT_SCHED_PERF_EN
    logic [31:0] issued_q, issued_d;
    logic [31:0] stall_q, stall_d;

    // Wrapping event counters.
    always_comb begin
        issued_d = issued_q + 32'(xfer);
        stall_d  = stall_q + 32'((|req_valid) && !issue_ok);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            issued_q <= '0;
            stall_q  <= '0;
        end else begin
            issued_q <= issued_d;
            stall_q  <= stall_d;
        end
    end

    assign perf_issued = issued_q;
    assign perf_stall  = stall_q;
`endif

endmodule

// File: tb/tb_fcvt_sched.sv
// tb_fcvt_sched: directed bench for fcvt_sched with a truncating int-to-float converter model.
module tb_fcvt_sched;

    localparam int unsigned N   = 3;
    localparam int unsigned IDW = 2;

    logic            clk;
    logic            rstn;
    logic [N-1:0]    req_valid;
    logic [N*32-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic [31:0]     cvt_x;
    logic [31:0]     cvt_y;
    logic            resp_valid;
    logic [31:0]     resp_data;
    logic [IDW-1:0]  resp_id;
    logic            resp_ready;

    fcvt_sched #(
        .N     (N),
        .IDW   (IDW),
        .DEPTH (4),
        .LAT   (2)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .cvt_x      (cvt_x),
        .cvt_y      (cvt_y),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_id    (resp_id),
        .resp_ready (resp_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Signed int to IEEE single, round toward zero.
    function automatic logic [31:0] i2f(input logic [31:0] x);
        logic [31:0] m;
        logic [31:0] sh;
        int          p;
        if (x == 32'd0) return 32'd0;
        m = x[31] ? (~x + 32'd1) : x;
        p = 0;
        for (int i = 0; i < 32; i++) if (m[i]) p = i;
        sh = m << (31 - p);
        return {x[31], 8'(127 + p), sh[30:8]};
    endfunction

    // Two-stage converter with no reset, as in the FPU.
    logic [31:0] cv_s1;
    always @(posedge clk) begin
        cv_s1 <= i2f(cvt_x);
        cvt_y <= cv_s1;
    end

    typedef struct packed {
        logic [31:0]    d;
        logic [IDW-1:0] id;
    } exp_t;

    exp_t            eq[$];
    int              n_cmp;
    int              n_bad;
    logic            nxt_rstn;
    logic [N-1:0]    nxt_valid;
    logic [N*32-1:0] nxt_data;
    logic            nxt_rr;
    logic [31:0]     t2_x [4];
    logic [31:0]     t2_f [4];
    logic [31:0]     t3_f [6];
    logic [31:0]     f_tab [16];
    logic [8:0]      t5_pat;
    int              nd;
    logic [N-1:0]    g;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Check the head against the oldest outstanding expected result.
    task automatic mon();
        if (resp_valid) begin
            if (eq.size() == 0) begin
                chk("spurious_resp", 32'(resp_valid), 32'd0);
            end else begin
                chk("resp_data", resp_data, eq[0].d);
                chk("resp_id", 32'(resp_id), 32'(eq[0].id));
                if (resp_ready) void'(eq.pop_front());
            end
        end
    endtask

    // Advance one cycle, apply queued inputs, let them settle, then monitor.
    task automatic step();
        @(posedge clk);
        #2;
        rstn       = nxt_rstn;
        req_valid  = nxt_valid;
        req_data   = nxt_data;
        resp_ready = nxt_rr;
        #1;
        mon();
    endtask

    // Check the grant and operand for this cycle; record the expected result.
    task automatic iss(input string tag, input logic [N-1:0] gx, input logic [31:0] x,
                       input logic [31:0] f, input logic [IDW-1:0] id);
        exp_t e;
        chk(tag, 32'(req_ready), 32'(gx));
        chk({tag, "_x"}, cvt_x, (gx != '0) ? x : 32'd0);
        if (gx != '0) begin
            e.d  = f;
            e.id = id;
            eq.push_back(e);
        end
    endtask

    // Drain with resp_ready high; all expected results must appear, then nothing more.
    task automatic drain(input string tag, input int budget);
        nxt_valid = '0;
        nxt_rr    = 1'b1;
        for (int i = 0; i < budget && eq.size() != 0; i++) step();
        chk({tag, "_left"}, 32'(eq.size()), 32'd0);
        step();
        chk({tag, "_extra"}, 32'(resp_valid), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rstn = 1'b0; req_valid = '0; req_data = '0; resp_ready = 1'b0;
        nxt_rstn = 1'b0; nxt_valid = '0; nxt_data = '0; nxt_rr = 1'b0;
        t2_x[0] = 32'hFFFFFFFF; t2_f[0] = 32'hBF800000;
        t2_x[1] = 32'h00000000; t2_f[1] = 32'h00000000;
        t2_x[2] = 32'h80000000; t2_f[2] = 32'hCF000000;
        t2_x[3] = 32'h7FFFFFFF; t2_f[3] = 32'h4EFFFFFF;
        t3_f[0] = 32'h40A00000; t3_f[1] = 32'h40C00000; t3_f[2] = 32'h40E00000;
        t3_f[3] = 32'h41000000; t3_f[4] = 32'h41100000; t3_f[5] = 32'h41200000;
        f_tab[0]  = 32'h00000000; f_tab[1]  = 32'h3F800000; f_tab[2]  = 32'h40000000;
        f_tab[3]  = 32'h40400000; f_tab[4]  = 32'h40800000; f_tab[5]  = 32'h40A00000;
        f_tab[6]  = 32'h40C00000; f_tab[7]  = 32'h40E00000; f_tab[8]  = 32'h41000000;
        f_tab[9]  = 32'h41100000; f_tab[10] = 32'h41200000; f_tab[11] = 32'h41300000;
        f_tab[12] = 32'h41400000; f_tab[13] = 32'h41500000; f_tab[14] = 32'h41600000;
        f_tab[15] = 32'h41700000;
        t5_pat = 9'b001001111;

        // Reset state
        repeat (2) @(posedge clk);
        #3;
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_data", resp_data, 32'd0);
        chk("rst_resp_id", 32'(resp_id), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_cvt_x", cvt_x, 32'd0);

        // Single op from requester 0, latency check
        nxt_rstn = 1'b1; nxt_rr = 1'b1;
        nxt_valid = 3'b001; nxt_data = {64'd0, 32'h00000001};
        step();
        iss("t1_gnt", 3'b001, 32'h1, 32'h3F800000, 2'd0);
        nxt_valid = '0;
        step(); chk("t1_lat_c1", 32'(resp_valid), 32'd0);
        step(); chk("t1_lat_c2", 32'(resp_valid), 32'd0);
        step(); chk("t1_lat_c3", 32'(resp_valid), 32'd1);
        step(); chk("t1_popped", 32'(resp_valid), 32'd0);

        // Boundary operands, back to back on requester 2
        for (int k = 0; k < 4; k++) begin
            nxt_valid = 3'b100;
            nxt_data  = {t2_x[k], 64'd0};
            step();
            iss("t2_gnt", 3'b100, t2_x[k], t2_f[k], 2'd2);
        end
        drain("t2_drain", 10);

        // All three requesters valid: round-robin order 0,1,2,0,1,2
        for (int k = 0; k < 6; k++) begin
            nxt_valid = 3'b111;
            nxt_data  = {3{32'(5 + k)}};
            step();
            g = 3'(1 << (k % 3));
            iss("t3_gnt", g, 32'(5 + k), t3_f[k], 2'(k % 3));
        end
        drain("t3_drain", 10);

        // Backpressure: requester 1 streams 8 ops, only 4 fit
        nd = 1;
        nxt_rr = 1'b0;
        for (int k = 0; k < 10; k++) begin
            nxt_valid = 3'b010;
            nxt_data  = {32'd0, 32'(nd), 32'd0};
            step();
            g = (k < 4) ? 3'b010 : 3'b000;
            iss("t4_hold_gnt", g, 32'(nd), f_tab[nd], 2'd1);
            if (g != '0) nd++;
        end
        chk("t4_full_valid", 32'(resp_valid), 32'd1);
        nxt_rr = 1'b1;
        for (int k = 0; k < 5; k++) begin
            nxt_valid = 3'b010;
            nxt_data  = {32'd0, 32'(nd), 32'd0};
            step();
            g = (k >= 1) ? 3'b010 : 3'b000;
            iss("t4_rel_gnt", g, 32'(nd), f_tab[nd], 2'd1);
            if (g != '0) nd++;
        end
        chk("t4_issued", 32'(nd), 32'd9);
        drain("t4_drain", 12);

        // Credit full, one op in flight; pop pulse on the landing edge
        nd = 9;
        for (int k = 0; k < 9; k++) begin
            nxt_rr    = (k == 5);
            nxt_valid = 3'b001;
            nxt_data  = {64'd0, 32'(nd)};
            step();
            g = t5_pat[k] ? 3'b001 : 3'b000;
            iss("t5_gnt", g, 32'(nd), f_tab[nd], 2'd0);
            if (g != '0) nd++;
            if (k == 6) chk("t5_head_after_pp", resp_data, 32'h41200000);
        end
        drain("t5_drain", 12);

        // Reset with a result at the head and two ops in flight
        nxt_rr = 1'b0;
        for (int k = 0; k < 3; k++) begin
            nxt_valid = 3'b010;
            nxt_data  = {32'd0, 32'(k + 1), 32'd0};
            step();
            iss("t6_pre_gnt", 3'b010, 32'(k + 1), f_tab[k + 1], 2'd1);
        end
        nxt_valid = '0;
        step();
        chk("t6_pre_valid", 32'(resp_valid), 32'd1);
        rstn = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(resp_valid), 32'd0);
        chk("t6_rst_data", resp_data, 32'd0);
        chk("t6_rst_id", 32'(resp_id), 32'd0);
        eq.delete();
        nxt_valid = 3'b111;
        nxt_data  = {32'd0, 32'hFFFFFFFE, 32'd16};
        step();
        iss("t6_gnt0", 3'b001, 32'd16, 32'h41800000, 2'd0);
        chk("t6_drop_c4", 32'(resp_valid), 32'd0);
        step();
        iss("t6_gnt1", 3'b010, 32'hFFFFFFFE, 32'hC0000000, 2'd1);
        chk("t6_drop_c5", 32'(resp_valid), 32'd0);
        nxt_valid = '0;
        nxt_rr    = 1'b1;
        step();
        chk("t6_drop_c6", 32'(resp_valid), 32'd0);
        drain("t6_drain", 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
